// File: rtl/hero_motion_ctrl_if.sv
// ----------------------------------------------------------------------------
// hero_motion_ctrl_if : direction/request inputs and position/status outputs
// Revision : 1.0
// ----------------------------------------------------------------------------
`default_nettype none

interface hero_motion_ctrl_if;
    logic [1:0] dir;
    logic       move_req;
    logic [9:0] x;
    logic [9:0] y;
    logic [1:0] facing;
    logic [1:0] frame;
    logic       moving;
    logic       turning;
    logic       at_wall;
    logic       step_pulse;

    modport master (
        output dir, move_req,
        input  x, y, facing, frame, moving, turning, at_wall, step_pulse
    );

    modport slave (
        input  dir, move_req,
        output x, y, facing, frame, moving, turning, at_wall, step_pulse
    );
endinterface

`default_nettype wire

// File: rtl/hero_motion_ctrl.sv
// ----------------------------------------------------------------------------
// hero_motion_ctrl : tick-prescaled IDLE/TURN/MOVE hero movement sequencer.
// Optional macro HERO_WRAP_EN : playfield edges wrap instead of clamp.
// Revision : 1.0
// ----------------------------------------------------------------------------
`default_nettype none

module hero_motion_ctrl #(
    parameter int TICK_DIV   = 500000,
    parameter int STEP       = 4,
    parameter int X_MAX      = 639,
    parameter int Y_MAX      = 479,
    parameter int X_INIT     = 320,
    parameter int Y_INIT     = 240,
    parameter int TURN_TICKS = 2
) (
    input  logic               clk,
    input  logic               rst_n,
    hero_motion_ctrl_if.slave  bus
);

    localparam int CNT_W = (TICK_DIV > 2) ? $clog2(TICK_DIV) : 1;
    localparam int TC_W  = (TURN_TICKS > 2) ? $clog2(TURN_TICKS) : 1;

    localparam logic [CNT_W-1:0] TICK_LAST   = CNT_W'(TICK_DIV - 1);
    localparam logic [TC_W-1:0]  TURN_RELOAD = TC_W'(TURN_TICKS - 1);
    localparam logic [10:0]      STEP_E      = 11'(STEP);
    localparam logic [10:0]      X_LIM       = 11'(X_MAX);
    localparam logic [10:0]      Y_LIM       = 11'(Y_MAX);

    typedef enum logic [1:0] {
        S_IDLE = 2'd0,
        S_TURN = 2'd1,
        S_MOVE = 2'd2
    } state_t;

    state_t           state_q;
    logic [CNT_W-1:0] cnt_q;
    logic [TC_W-1:0]  turn_cnt_q;
    logic [9:0]       x_q;
    logic [9:0]       y_q;
    logic [1:0]       facing_q;
    logic [1:0]       frame_q;
    logic             moving_q;
    logic             turning_q;
    logic             at_wall_q;
    logic             step_pulse_q;

    logic             tick;
    logic             do_step;
    logic [10:0]      coord_ext;
    logic [10:0]      lim_ext;
    logic [10:0]      res_ext;
    logic [9:0]       coord_d;
    logic             wall_d;
    logic             changed;

    assign tick    = (cnt_q == TICK_LAST);
    // A step happens whenever a held request matches facing outside TURN.
    assign do_step = tick && bus.move_req && (bus.dir == facing_q) && (state_q != S_TURN);

    // Facing bit 1 selects the x axis; bit 0 selects the increasing direction.
    always_comb begin
        coord_ext = facing_q[1] ? {1'b0, x_q} : {1'b0, y_q};
        lim_ext   = facing_q[1] ? X_LIM : Y_LIM;
        res_ext   = coord_ext;
        wall_d    = 1'b0;
        if (facing_q[0]) begin
            if (coord_ext + STEP_E > lim_ext) begin
`ifdef HERO_WRAP_EN
                res_ext = coord_ext + STEP_E - (lim_ext + 11'd1);
`else
                res_ext = lim_ext;
                wall_d  = 1'b1;
`endif
            end else begin
                res_ext = coord_ext + STEP_E;
            end
        end else begin
            if (coord_ext < STEP_E) begin
`ifdef HERO_WRAP_EN
                res_ext = coord_ext + lim_ext + 11'd1 - STEP_E;
`else
                res_ext = 11'd0;
                wall_d  = 1'b1;
`endif
            end else begin
                res_ext = coord_ext - STEP_E;
            end
        end
        coord_d = res_ext[9:0];
        changed = (res_ext != coord_ext);
    end

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            state_q      <= S_IDLE;
            cnt_q        <= '0;
            turn_cnt_q   <= '0;
            x_q          <= 10'(X_INIT);
            y_q          <= 10'(Y_INIT);
            facing_q     <= 2'b00;
            frame_q      <= 2'd0;
            moving_q     <= 1'b0;
            turning_q    <= 1'b0;
            at_wall_q    <= 1'b0;
            step_pulse_q <= 1'b0;
        end else begin
            step_pulse_q <= 1'b0;
            cnt_q        <= tick ? '0 : cnt_q + 1'b1;
            if (tick) begin
                case (state_q)
                    S_IDLE: begin
                        if (bus.move_req && (bus.dir != facing_q)) begin
                            facing_q   <= bus.dir;
                            turn_cnt_q <= TURN_RELOAD;
                            state_q    <= S_TURN;
                            turning_q  <= 1'b1;
                        end else if (bus.move_req) begin
                            state_q  <= S_MOVE;
                            moving_q <= 1'b1;
                        end
                    end
                    S_TURN: begin
                        if (!bus.move_req) begin
                            state_q   <= S_IDLE;
                            turning_q <= 1'b0;
                        end else if (bus.dir != facing_q) begin
                            facing_q   <= bus.dir;
                            turn_cnt_q <= TURN_RELOAD;
                        end else if (turn_cnt_q == '0) begin
                            state_q   <= S_MOVE;
                            turning_q <= 1'b0;
                            moving_q  <= 1'b1;
                        end else begin
                            turn_cnt_q <= turn_cnt_q - 1'b1;
                        end
                    end
                    S_MOVE: begin
                        if (!bus.move_req) begin
                            state_q   <= S_IDLE;
                            moving_q  <= 1'b0;
                            frame_q   <= 2'd0;
                            at_wall_q <= 1'b0;
                        end else if (bus.dir != facing_q) begin
                            facing_q   <= bus.dir;
                            turn_cnt_q <= TURN_RELOAD;
                            state_q    <= S_TURN;
                            moving_q   <= 1'b0;
                            turning_q  <= 1'b1;
                            at_wall_q  <= 1'b0;
                        end
                    end
                    default: begin
                        state_q   <= S_IDLE;
                        moving_q  <= 1'b0;
                        turning_q <= 1'b0;
                    end
                endcase
            end
            if (do_step) begin
                if (facing_q[1]) begin
                    x_q <= coord_d;
                end else begin
                    y_q <= coord_d;
                end
                at_wall_q <= wall_d;
                if (changed) begin
                    step_pulse_q <= 1'b1;
                    frame_q      <= frame_q + 2'd1;
                end
            end
        end
    end

    assign bus.x          = x_q;
    assign bus.y          = y_q;
    assign bus.facing     = facing_q;
    assign bus.frame      = frame_q;
    assign bus.moving     = moving_q;
    assign bus.turning    = turning_q;
    assign bus.at_wall    = at_wall_q;
    assign bus.step_pulse = step_pulse_q;

endmodule

`default_nettype wire

// File: tb/tb_hero_motion_ctrl.sv
// ----------------------------------------------------------------------------
// tb_hero_motion_ctrl : directed self-checking bench for hero_motion_ctrl
// Revision : 1.0
// ----------------------------------------------------------------------------
`default_nettype none

module tb_hero_motion_ctrl;

    logic clk;
    logic rst_n;
    int   n_checks;
    int   n_pass;

    hero_motion_ctrl_if bus ();

    hero_motion_ctrl #(
        .TICK_DIV   (4),
        .STEP       (4),
        .X_MAX      (15),
        .Y_MAX      (15),
        .X_INIT     (8),
        .Y_INIT     (8),
        .TURN_TICKS (2)
    ) u_dut (
        .clk   (clk),
        .rst_n (rst_n),
        .bus   (bus.slave)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_checks++;
        if (got === exp) begin
            n_pass++;
        end else begin
            $display("FAIL %s: got %0d expected %0d", tag, got, exp);
        end
    endtask

    // Advance n rising edges and settle 1 time unit past the last one.
    task automatic clks(input int n);
        repeat (n) @(posedge clk);
        #1;
    endtask

    initial begin
        n_checks     = 0;
        n_pass       = 0;
        rst_n        = 1'b0;
        bus.dir      = 2'b00;
        bus.move_req = 1'b0;

        // Reset state
        clks(2);
        chk("rst_x", 32'(bus.x), 32'd8);
        chk("rst_y", 32'(bus.y), 32'd8);
        chk("rst_facing", 32'(bus.facing), 32'd0);
        chk("rst_frame", 32'(bus.frame), 32'd0);
        chk("rst_flags", {28'd0, bus.moving, bus.turning, bus.at_wall, bus.step_pulse}, 32'd0);
        rst_n = 1'b1;

        // Hold up: nothing before the 4th clock, then a step
        bus.dir      = 2'b00;
        bus.move_req = 1'b1;
        clks(3);
        chk("pre_tick_y", 32'(bus.y), 32'd8);
        chk("pre_tick_moving", 32'(bus.moving), 32'd0);
        clks(1);
        chk("up1_y", 32'(bus.y), 32'd4);
        chk("up1_pulse", 32'(bus.step_pulse), 32'd1);
        chk("up1_frame", 32'(bus.frame), 32'd1);
        chk("up1_moving", 32'(bus.moving), 32'd1);
        clks(1);
        chk("up1_pulse_end", 32'(bus.step_pulse), 32'd0);
        clks(3);
        chk("up2_y", 32'(bus.y), 32'd0);
        chk("up2_frame", 32'(bus.frame), 32'd2);
        chk("up2_wall", 32'(bus.at_wall), 32'd0);

        // Pushing into the top edge
        clks(4);
`ifdef HERO_WRAP_EN
        chk("up3_y", 32'(bus.y), 32'd12);
        chk("up3_wall", 32'(bus.at_wall), 32'd0);
        chk("up3_pulse", 32'(bus.step_pulse), 32'd1);
        chk("up3_frame", 32'(bus.frame), 32'd3);
`else
        chk("up3_y", 32'(bus.y), 32'd0);
        chk("up3_wall", 32'(bus.at_wall), 32'd1);
        chk("up3_pulse", 32'(bus.step_pulse), 32'd0);
        chk("up3_frame", 32'(bus.frame), 32'd2);
`endif

        // Off-tick direction glitch is ignored
        clks(1);
        bus.dir = 2'b01;
        clks(1);
        bus.dir = 2'b00;
        clks(2);
        chk("glitch_facing", 32'(bus.facing), 32'd0);
        chk("glitch_moving", 32'(bus.moving), 32'd1);

        // Release in MOVE
        bus.move_req = 1'b0;
        clks(4);
        chk("rel_moving", 32'(bus.moving), 32'd0);
        chk("rel_frame", 32'(bus.frame), 32'd0);
        chk("rel_wall", 32'(bus.at_wall), 32'd0);
        chk("rel_x", 32'(bus.x), 32'd8);

        // Turn right then walk to the right edge
        bus.dir      = 2'b11;
        bus.move_req = 1'b1;
        clks(4);
        chk("t1_turning", 32'(bus.turning), 32'd1);
        chk("t1_facing", 32'(bus.facing), 32'd3);
        chk("t1_x", 32'(bus.x), 32'd8);
        clks(4);
        chk("t2_turning", 32'(bus.turning), 32'd1);
        clks(4);
        chk("t3_moving", 32'(bus.moving), 32'd1);
        chk("t3_turning", 32'(bus.turning), 32'd0);
        chk("t3_x", 32'(bus.x), 32'd8);
        chk("t3_pulse", 32'(bus.step_pulse), 32'd0);
        clks(4);
        chk("t4_x", 32'(bus.x), 32'd12);
        chk("t4_frame", 32'(bus.frame), 32'd1);
        clks(4);
`ifdef HERO_WRAP_EN
        chk("t5_x", 32'(bus.x), 32'd0);
        chk("t5_wall", 32'(bus.at_wall), 32'd0);
`else
        chk("t5_x", 32'(bus.x), 32'd15);
        chk("t5_wall", 32'(bus.at_wall), 32'd1);
`endif
        chk("t5_pulse", 32'(bus.step_pulse), 32'd1);
        chk("t5_frame", 32'(bus.frame), 32'd2);

        // Direction change while moving re-enters TURN and clears at_wall
        bus.dir = 2'b10;
        clks(4);
        chk("mt_turning", 32'(bus.turning), 32'd1);
        chk("mt_moving", 32'(bus.moving), 32'd0);
        chk("mt_facing", 32'(bus.facing), 32'd2);
        chk("mt_wall", 32'(bus.at_wall), 32'd0);

        // Reset during TURN
        rst_n = 1'b0;
        clks(1);
        chk("rt_x", 32'(bus.x), 32'd8);
        chk("rt_y", 32'(bus.y), 32'd8);
        chk("rt_facing", 32'(bus.facing), 32'd0);
        chk("rt_frame", 32'(bus.frame), 32'd0);
        chk("rt_flags", {28'd0, bus.moving, bus.turning, bus.at_wall, bus.step_pulse}, 32'd0);
        rst_n = 1'b1;

        // TURN abandoned when the button is released
        bus.dir = 2'b01;
        clks(4);
        chk("ta_turning", 32'(bus.turning), 32'd1);
        bus.move_req = 1'b0;
        clks(4);
        chk("ta_idle", 32'(bus.turning), 32'd0);
        chk("ta_y", 32'(bus.y), 32'd8);

        $display("%0d/%0d checks passed", n_pass, n_checks);
        $finish;
    end

endmodule

`default_nettype wire
